tick_timer_ctrl: RTL and testbench
==================================

// Module: tick_timer_ctrl
// PURPOSE
//  Multi-channel timer scheduler driven by the shared 1-cycle prescaler strobe (tick_in).
//  Lets N_CH independent software-style timers share one prescaler instead of instancing one each.
//  Each channel: programmable period in ticks, one-shot/periodic mode, stop/resume/clear.
//  Sits between the prescaler and the consumers (FSMs, display refresh, LED blinkers).
// PARAMETERS
//  N_CH    4   number of timer channels (>=2)
//  CNT_W   16  period/counter width in ticks
// PORTS
//  clk           in   1              system clock
//  rst           in   1              synchronous, active-high reset
//  tick_in       in   1              prescaler strobe, exactly 1 clk wide
//  cfg_valid     in   1              command valid
//  cfg_ready     out  1              command ready; transfer = cfg_valid & cfg_ready
//  cfg_ch        in   $clog2(N_CH)   target channel
//  cfg_cmd       in   2              0=LOAD_START 1=STOP 2=RESUME 3=CLEAR
//  cfg_period    in   CNT_W          period in ticks (LOAD_START only)
//  cfg_periodic  in   1              1=auto-reload, 0=one-shot (LOAD_START only)
//  cfg_err       out  1              1-cycle pulse: LOAD_START with period 0, or cfg_ch >= N_CH
//  expire        out  N_CH           1-cycle expiry pulse per channel
//  running       out  N_CH           channel state == RUN
//  pending       out  N_CH           sticky expiry flags
//  irq_ack       in   N_CH           per-bit clear of pending
//  irq           out  1              OR of pending
// BEHAVIOUR
//  - Reset: all channels IDLE, count=0, pending=0, expire=0, cfg_err=0; cfg_ready=1 after reset.
//  - cfg_ready = ~tick_in (combinational); commands never land in a tick cycle.
//  - Per-channel FSM {IDLE, RUN, PAUSED}:
//    LOAD_START (any state): period!=0 -> count<=period, mode latched, RUN;
//      period==0 -> channel unchanged, cfg_err pulse next cycle.
//    STOP:   RUN -> PAUSED, count held; no effect in IDLE/PAUSED.
//    RESUME: PAUSED -> RUN, count kept; no effect in IDLE/RUN.
//    CLEAR:  any -> IDLE, count=0, pending bit cleared (overrides set in same cycle).
//  - Tick processing (tick_in=1, channel RUN):
//    count>1 -> count-1.
//    count==1 -> expire[ch]=1 in the following cycle, pending[ch] set;
//      periodic -> count<=period (expire every `period` ticks);
//      one-shot -> IDLE, count=0.
//  - PAUSED/IDLE channels ignore ticks. All channels are evaluated in parallel in the same tick.
//  - pending: set wins over irq_ack in the same cycle; ack of a 0 bit has no effect.
//  - Latency: command -> state visible on running the next cycle; tick -> expire 1 cycle.
//  - cfg_ch >= N_CH (non-power-of-2 N_CH): command dropped, cfg_err pulse.
//  - Reset mid-operation: immediate return to reset values; no expire is emitted.
//  - Counter arithmetic is unsigned CNT_W; no wrap is possible (stops at 1).
// STRUCTURE
//  - Package tick_timer_pkg: cmd_e enum (CMD_LOAD_START..CMD_CLEAR), chan_state_e enum
//    {ST_IDLE, ST_RUN, ST_PAUSED}, chan_cfg_t struct {period, periodic}.
//  - Sub-module tick_timer_chan: one channel FSM + counter + pending bit; instantiated
//    N_CH times by generate; top holds the command decode, cfg_err and irq OR.
// TESTING
//  1 LOAD_START ch0 period=3 periodic, 10 ticks -> expire[0] after ticks 3,6,9; running[0]=1.
//  2 LOAD_START ch1 period=2 one-shot, 5 ticks -> single expire[1] after tick 2; running[1]=0.
//  3 ch2 period=5, 2 ticks, STOP, 4 ticks, RESUME -> expire[2] exactly 3 ticks after RESUME.
//  4 irq_ack[0] in the same cycle ch0 expires -> pending[0] stays 1, irq=1.
//  5 LOAD_START period=0 -> cfg_err pulse, channel stays IDLE; cfg_valid during tick_in -> not accepted.
//  6 rst asserted while 3 channels RUN -> next cycle running=0, pending=0, no expire pulses.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg: shared command/state encodings and channel config type for the tick timer.
package tick_timer_pkg;
    localparam int DEF_CNT_W = 16;
    typedef enum logic [1:0] {
        CMD_LOAD_START = 2'd0,
        CMD_STOP       = 2'd1,
        CMD_RESUME     = 2'd2,
        CMD_CLEAR      = 2'd3
    } cmd_e;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } chan_state_e;
    typedef struct packed {
        logic [DEF_CNT_W-1:0] period;
        logic                 periodic;
    } chan_cfg_t;
endpackage

// File: rtl/tick_timer_chan.sv
// tick_timer_chan: one timer channel -- IDLE/RUN/PAUSED FSM, tick down-counter and sticky pending flag.
module tick_timer_chan
    import tick_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             cmd_valid_i,
    input  cmd_e             cmd_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             periodic_i,
    input  logic             ack_i,
    output logic             expire_o,
    output logic             running_o,
    output logic             pending_o
);
    chan_state_e      state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] period_q;
    logic             periodic_q;
    logic             expire_q;
    logic             pending_q;

    assign expire_o  = expire_q;
    assign running_o = (state_q == ST_RUN);
    assign pending_o = pending_q;

    // Commands and ticks are mutually exclusive (cfg_ready = ~tick), so one branch per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            expire_q   <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            expire_q  <= 1'b0;
            pending_q <= pending_q & ~ack_i;
            if (cmd_valid_i) begin
                case (cmd_i)
                    CMD_LOAD_START: begin
                        state_q    <= ST_RUN;
                        count_q    <= period_i;
                        period_q   <= period_i;
                        periodic_q <= periodic_i;
                    end
                    CMD_STOP:   if (state_q == ST_RUN) state_q <= ST_PAUSED;
                    CMD_RESUME: if (state_q == ST_PAUSED) state_q <= ST_RUN;
                    default: begin
                        state_q   <= ST_IDLE;
                        count_q   <= '0;
                        pending_q <= 1'b0;
                    end
                endcase
            end else if (tick_i && state_q == ST_RUN) begin
                if (count_q > CNT_W'(1)) begin
                    count_q <= count_q - CNT_W'(1);
                end else begin
                    expire_q  <= 1'b1;
                    pending_q <= 1'b1;
                    count_q   <= periodic_q ? period_q : '0;
                    state_q   <= periodic_q ? ST_RUN : ST_IDLE;
                end
            end
        end
    end
endmodule

// File: rtl/tick_timer_ctrl.sv
// tick_timer_ctrl: N_CH timers sharing one prescaler tick; command decode, error pulse and irq OR.
module tick_timer_ctrl
    import tick_timer_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_in,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [1:0]              cfg_cmd,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic                    cfg_periodic,
    output logic                    cfg_err,
    output logic [N_CH-1:0]         expire,
    output logic [N_CH-1:0]         running,
    output logic [N_CH-1:0]         pending,
    input  logic [N_CH-1:0]         irq_ack,
    output logic                    irq
);
    localparam int CH_W = $clog2(N_CH);

    cmd_e cmd;
    logic fire;
    logic bad;
    logic cmd_ok;
    logic cfg_err_q;

    assign cmd       = cmd_e'(cfg_cmd);
    assign cfg_ready = ~tick_in;
    assign fire      = cfg_valid & cfg_ready;
    assign bad       = (int'(cfg_ch) >= N_CH) | (cmd == CMD_LOAD_START && cfg_period == '0);
    assign cmd_ok    = fire & ~bad;
    assign cfg_err   = cfg_err_q;
    assign irq       = |pending;

    always_ff @(posedge clk) begin
        if (rst) cfg_err_q <= 1'b0;
        else     cfg_err_q <= fire & bad;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_timer_chan #(.CNT_W(CNT_W)) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick_i     (tick_in),
            .cmd_valid_i(cmd_ok && cfg_ch == CH_W'(i)),
            .cmd_i      (cmd),
            .period_i   (cfg_period),
            .periodic_i (cfg_periodic),
            .ack_i      (irq_ack[i]),
            .expire_o   (expire[i]),
            .running_o  (running[i]),
            .pending_o  (pending[i])
        );
    end
endmodule

// File: tb/tb_tick_timer_ctrl.sv
// tb_tick_timer_ctrl: directed scenarios plus random traffic against a tick-level timer model.
module tb_tick_timer_ctrl;
    localparam int N_CH  = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick_in = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [1:0]       cfg_ch = '0;
    logic [1:0]       cfg_cmd = '0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic             cfg_periodic = 1'b0;
    logic             cfg_err;
    logic [N_CH-1:0]  expire, running, pending, irq_ack = '0;
    logic             irq;

    tick_timer_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_cmd(cfg_cmd), .cfg_period(cfg_period), .cfg_periodic(cfg_periodic),
        .cfg_err(cfg_err), .expire(expire), .running(running), .pending(pending),
        .irq_ack(irq_ack), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic rdy_s;

    // Model: each running channel has ticks remaining until it fires.
    logic [N_CH-1:0] m_run = '0, m_pause = '0, m_pdc = '0, m_pend = '0, m_exp = '0;
    int m_rem[N_CH];
    int m_per[N_CH];
    bit m_err = 0;

    task automatic drive(input bit r, input bit tk, input bit v, input int ch, input int cmd,
                         input int per, input bit pdc, input logic [N_CH-1:0] ack);
        rst = r; tick_in = tk; cfg_valid = v; cfg_ch = 2'(ch); cfg_cmd = 2'(cmd);
        cfg_period = CNT_W'(per); cfg_periodic = pdc; irq_ack = ack;
        #1 rdy_s = cfg_ready;
        @(posedge clk);
        if (r) begin
            m_run = '0; m_pause = '0; m_pend = '0; m_exp = '0; m_err = 0;
            for (int i = 0; i < N_CH; i++) m_rem[i] = 0;
        end else begin
            m_exp = '0; m_err = 0; m_pend = m_pend & ~ack;
            if (v && !tk) begin
                if (ch >= N_CH || (cmd == 0 && per == 0)) m_err = 1;
                else if (cmd == 0) begin
                    m_rem[ch] = per; m_per[ch] = per; m_pdc[ch] = pdc; m_run[ch] = 1; m_pause[ch] = 0;
                end else if (cmd == 1 && m_run[ch]) begin
                    m_run[ch] = 0; m_pause[ch] = 1;
                end else if (cmd == 2 && m_pause[ch]) begin
                    m_run[ch] = 1; m_pause[ch] = 0;
                end else if (cmd == 3) begin
                    m_run[ch] = 0; m_pause[ch] = 0; m_rem[ch] = 0; m_pend[ch] = 0;
                end
            end
            if (tk) for (int i = 0; i < N_CH; i++) if (m_run[i]) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_exp[i] = 1; m_pend[i] = 1;
                    if (m_pdc[i]) m_rem[i] = m_per[i];
                    else m_run[i] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic tick(input logic [N_CH-1:0] ack);
        drive(0, 1, 0, 0, 0, 0, 0, ack);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, '0);
        drive(1, 0, 0, 0, 0, 0, 0, '0);
        idle();
        n_cmp++; if (running !== '0) begin n_fail++; $display("FAIL reset_running got=%b want=0000", running); end
        n_cmp++; if (pending !== '0) begin n_fail++; $display("FAIL reset_pending got=%b want=0000", pending); end
        n_cmp++; if (expire !== '0) begin n_fail++; $display("FAIL reset_expire got=%b want=0000", expire); end
        n_cmp++; if ({irq, cfg_err} !== 2'b00) begin n_fail++; $display("FAIL reset_irq_err got=%b want=00", {irq, cfg_err}); end
        n_cmp++; if (rdy_s !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", rdy_s); end
    endtask

    task automatic test_periodic();
        int n_exp = 0;
        drive(0, 0, 1, 0, 0, 3, 1, '0);
        n_cmp++; if (running[0] !== 1'b1) begin n_fail++; $display("FAIL periodic_start got=%b want=1", running[0]); end
        for (int k = 1; k <= 10; k++) begin
            tick('0);
            n_exp += int'(expire[0]);
            n_cmp++; if (expire[0] !== ((k % 3) == 0)) begin n_fail++; $display("FAIL periodic_tick%0d got=%b want=%b", k, expire[0], (k % 3) == 0); end
            idle();
            n_cmp++; if (expire[0] !== 1'b0) begin n_fail++; $display("FAIL periodic_gap%0d got=%b want=0", k, expire[0]); end
        end
        n_cmp++; if (n_exp != 3 || running[0] !== 1'b1) begin n_fail++; $display("FAIL periodic_total got=%0d/%b want=3/1", n_exp, running[0]); end
    endtask

    task automatic test_oneshot();
        int n_exp = 0;
        drive(0, 0, 1, 1, 0, 2, 0, '0);
        for (int k = 1; k <= 5; k++) begin
            tick('0);
            n_exp += int'(expire[1]);
            n_cmp++; if (expire[1] !== (k == 2)) begin n_fail++; $display("FAIL oneshot_tick%0d got=%b want=%b", k, expire[1], k == 2); end
            idle();
        end
        n_cmp++; if (n_exp != 1 || running[1] !== 1'b0 || pending[1] !== 1'b1) begin
            n_fail++; $display("FAIL oneshot_end got=%0d/%b/%b want=1/0/1", n_exp, running[1], pending[1]);
        end
    endtask

    task automatic test_stop_resume();
        drive(0, 0, 1, 2, 0, 5, 0, '0);
        tick('0); idle(); tick('0); idle();
        drive(0, 0, 1, 2, 1, 0, 0, '0);
        n_cmp++; if (running[2] !== 1'b0) begin n_fail++; $display("FAIL stop_running got=%b want=0", running[2]); end
        for (int k = 0; k < 4; k++) begin
            tick('0);
            n_cmp++; if (expire[2] !== 1'b0 || running[2] !== 1'b0) begin n_fail++; $display("FAIL paused_tick%0d got=%b%b want=00", k, expire[2], running[2]); end
            idle();
        end
        drive(0, 0, 1, 2, 2, 0, 0, '0);
        n_cmp++; if (running[2] !== 1'b1) begin n_fail++; $display("FAIL resume_running got=%b want=1", running[2]); end
        for (int k = 1; k <= 4; k++) begin
            tick('0);
            n_cmp++; if (expire[2] !== (k == 3)) begin n_fail++; $display("FAIL resume_tick%0d got=%b want=%b", k, expire[2], k == 3); end
            idle();
        end
    endtask

    task automatic test_ack_race();
        drive(0, 0, 0, 0, 0, 0, 0, 4'b0001);
        n_cmp++; if (pending[0] !== 1'b0) begin n_fail++; $display("FAIL ack_clear got=%b want=0", pending[0]); end
        for (int k = 0; k < 6 && m_rem[0] != 1; k++) begin tick('0); idle(); end
        tick(4'b0001);
        n_cmp++; if ({expire[0], pending[0], irq} !== 3'b111) begin
            n_fail++; $display("FAIL ack_race got=%b want=111", {expire[0], pending[0], irq});
        end
        drive(0, 0, 0, 0, 0, 0, 0, 4'b1000);
        n_cmp++; if (pending !== m_pend) begin n_fail++; $display("FAIL ack_zero_bit got=%b want=%b", pending, m_pend); end
    endtask

    task automatic test_errors();
        drive(0, 0, 1, 3, 0, 0, 1, '0);
        n_cmp++; if ({cfg_err, running[3]} !== 2'b10) begin n_fail++; $display("FAIL zero_period got=%b want=10", {cfg_err, running[3]}); end
        idle();
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width got=%b want=0", cfg_err); end
        drive(0, 1, 1, 3, 0, 4, 1, '0);
        n_cmp++; if (rdy_s !== 1'b0) begin n_fail++; $display("FAIL ready_in_tick got=%b want=0", rdy_s); end
        idle();
        n_cmp++; if ({cfg_err, running[3]} !== 2'b00) begin n_fail++; $display("FAIL cmd_in_tick got=%b want=00", {cfg_err, running[3]}); end
        drive(0, 0, 1, 2, 3, 0, 0, '0);
        n_cmp++; if ({running[2], pending[2]} !== 2'b00) begin n_fail++; $display("FAIL clear got=%b want=00", {running[2], pending[2]}); end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) drive(0, 0, 1, c, 0, 2, 1, '0);
        tick('0); idle();
        drive(1, 1, 0, 0, 0, 0, 0, '0);
        n_cmp++; if ({running, pending, expire, irq} !== '0) begin
            n_fail++; $display("FAIL reset_mid got=%b/%b/%b/%b want=all0", running, pending, expire, irq);
        end
        idle();
        n_cmp++; if ({expire, running} !== '0) begin n_fail++; $display("FAIL reset_mid_after got=%b/%b want=0", expire, running); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bit tk = ($urandom_range(0, 2) == 0);
            drive($urandom_range(0, 199) == 0, tk, $urandom_range(0, 1), $urandom_range(0, N_CH - 1),
                  $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0) ? N_CH'($urandom) : '0);
            n_cmp++; if (rdy_s !== !tk) begin n_fail++; $display("FAIL rnd_ready c%0d got=%b want=%b", n, rdy_s, !tk); end
            n_cmp++; if (expire !== m_exp) begin n_fail++; $display("FAIL rnd_expire c%0d got=%b want=%b", n, expire, m_exp); end
            n_cmp++; if (running !== m_run) begin n_fail++; $display("FAIL rnd_running c%0d got=%b want=%b", n, running, m_run); end
            n_cmp++; if (pending !== m_pend || irq !== |m_pend) begin n_fail++; $display("FAIL rnd_pending c%0d got=%b/%b want=%b", n, pending, irq, m_pend); end
            n_cmp++; if (cfg_err !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d got=%b want=%b", n, cfg_err, m_err); end
        end
    endtask

    initial begin
        for (int i = 0; i < N_CH; i++) begin m_rem[i] = 0; m_per[i] = 0; end
        test_reset();
        test_periodic();
        test_oneshot();
        test_stop_resume();
        test_ack_race();
        test_errors();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
